// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional fetch timeout is enabled with the IFU_TIMEOUT_EN macro (see instr_fetch_unit).
package ifu_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OFFSET_W = 10;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register with next-PC selection: sign-extended branch offset,
// sequential +2, or hold; arithmetic wraps modulo 2^ADDR_W and bit 0 is kept clear.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                branch_en,
  input  logic                en_pc_2,
  input  logic [OFFSET_W-1:0] pc_offset,
  output logic [ADDR_W-1:0]   pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] step;

  always_comb begin
    step = '0;
    if (branch_en) begin
      // Word offset -> byte offset: sign-extend then append a zero LSB.
      step = {{(ADDR_W-OFFSET_W-1){pc_offset[OFFSET_W-1]}}, pc_offset, 1'b0};
    end else if (en_pc_2) begin
      step = ADDR_W'(2);
    end

    pc_d = pc_q;
    if (load) begin
      pc_d = pc_q + step;
    end
    pc_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= {RESET_PC[ADDR_W-1:1], 1'b0};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: FSM, instruction register, inst_load pulse and PC control.
// Define IFU_TIMEOUT_EN to enable the fetch timeout counter, fetch_err flag and ERR state.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_inc,
  input  logic                en_pc_2,
  input  logic                branch_en,
  input  logic [OFFSET_W-1:0] pc_offset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ack,
  output logic [INSTR_W-1:0]  instruction,
  output logic                inst_load,
  output logic [ADDR_W-1:0]   pc,
  output logic [1:0]          ifu_state,
  output logic                fetch_err
);

  ifu_state_e         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               inst_load_q, inst_load_d;
  logic               pc_load;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    inst_load_d = 1'b0;
    pc_load     = 1'b0;
`ifdef IFU_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
`ifdef IFU_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d     = imem_rdata;
          inst_load_d = 1'b1;
          state_d     = ST_HOLD;
        end
`ifdef IFU_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
`endif
      end
      ST_HOLD: begin
        if (pc_inc) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
`ifdef IFU_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      default: begin
        // ERR is terminal; only rst leaves it.
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      instr_q     <= NOP;
      inst_load_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      inst_load_q <= inst_load_d;
`ifdef IFU_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .branch_en (branch_en),
    .en_pc_2   (en_pc_2),
    .pc_offset (pc_offset),
    .pc        (pc)
  );

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign inst_load   = inst_load_q;
  assign ifu_state   = state_q;

`ifdef IFU_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 16-bit processor, sitting directly upstream of `control_unit`. It owns the program counter and fetches one 16-bit instruction per request from an instruction memory with variable-latency ready/ack timing. It holds the fetched word on `instruction` and pulses `inst_load` when a new word is valid. It advances the PC only when the control unit asserts `pc_inc`, using `en_pc_2`, `branch_en` and `pc_offset`.

## Interface
- `ADDR_W`, 16: PC / instruction-memory byte-address width.
- `RESET_PC`, 16'h0000: PC value after reset; must be even.
- `TIMEOUT_CYCLES`, 15: maximum FETCH cycles without `imem_ack`; used only with `IFU_TIMEOUT_EN`.
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `pc_inc`, in, 1: from control unit; load the next PC (accepted only in HOLD).
- `en_pc_2`, in, 1: next PC = PC+2.
- `branch_en`, in, 1: next PC = PC + (sext(`pc_offset`)<<1); takes priority over `en_pc_2`.
- `pc_offset`, in, 10: signed word offset.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, ADDR_W: fetch address; equals `pc`.
- `imem_rdata`, in, 16: instruction word; valid when `imem_ack`=1.
- `imem_ack`, in, 1: memory completion; meaningful only while `imem_req`=1.
- `instruction`, out, 16: instruction register, to control unit.
- `inst_load`, out, 1: one-cycle pulse when `instruction` has been updated.
- `pc`, out, ADDR_W: current PC.
- `ifu_state`, out, 2: current FSM state (debug).
- `fetch_err`, out, 1: sticky fetch timeout flag.

## Operation
- States: RESET=0, FETCH=1, HOLD=2, ERR=3.
- Reset values:
  - `pc`=RESET_PC, `instruction`=16'h0000
  - `inst_load`=0, `imem_req`=0, `fetch_err`=0
  - state=RESET, timeout counter=0
- RESET → FETCH unconditionally on the first edge with `rst`=0.
- FETCH: `imem_req`=1 with `imem_addr`=`pc`.
  - On an edge with `imem_ack`=1: `instruction`←`imem_rdata`, `inst_load`←1, go to HOLD.
- HOLD: `imem_req`=0.
  - `pc_inc`=0: stay in HOLD; `instruction` and `pc` are held.
  - `pc_inc`=1: update `pc` per the rule below, go to FETCH.
- Next-PC rule, evaluated only when `pc_inc`=1 in HOLD:
  - `branch_en`=1: PC + (sext(`pc_offset`)<<1); range -1024..+1022 bytes.
  - else `en_pc_2`=1: PC+2.
  - else: PC is unchanged (refetch of the same word).
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFE+2 → 16'h0000; 16'h0004 + (-4<<1) → 16'hFFFC.
- PC bit 0 is forced to 0 in the register.
- `pc_inc` in RESET, FETCH or ERR is ignored; no PC change.
- `imem_ack` while `imem_req`=0 is ignored.
- `rst` has priority in every state. A fetch in flight is abandoned: `imem_req` is low on the cycle after the reset edge. The memory must drop a pending response when `imem_req` deasserts.

## Timing
- Zero-wait memory (ack in the first FETCH cycle): `inst_load` high in the cycle after the ack edge. Fetch latency is 1 cycle.
- N wait cycles: the ack arrives in FETCH cycle N+1; `instruction` is updated at that edge.
- `pc_inc` is allowed in the same cycle as `inst_load` (first HOLD cycle).
- Minimum throughput: 2 cycles per instruction (FETCH, HOLD).
- After reset deasserts: `imem_req` rises 1 cycle later.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - A 4-bit-plus counter counts consecutive FETCH cycles without ack.
  - When the count reaches TIMEOUT_CYCLES: `fetch_err`←1, `imem_req` drops, state→ERR.
  - ERR is left only via `rst`. The counter clears on entry to FETCH.
- `IFU_TIMEOUT_EN` undefined:
  - No counter; FETCH waits indefinitely.
  - `fetch_err` is tied 0, ERR is unreachable, and TIMEOUT_CYCLES is unused.

## Structure
- Package `ifu_pkg`: state encoding constants (RESET/FETCH/HOLD/ERR), `INSTR_W`=16, `OFFSET_W`=10, NOP constant 16'h0000.
- One sub-module, `ifu_pc_reg`: PC register plus next-PC adder/mux with sign extension and wrap.
- The top level holds the FSM, instruction register, `inst_load` pulse and the timeout counter.

## Test plan
- Reset release, zero-wait memory returning 16'h4C4D at address 0:
  - `imem_req` rises 1 cycle after reset release with `imem_addr`=0.
  - `instruction`=16'h4C4D and a single `inst_load` pulse.
- 3-wait-state memory:
  - `imem_req` stays high 4 cycles.
  - `inst_load` fires once; `pc` is unchanged until `pc_inc`.
- HOLD with pc=16'h0010, plus:
  - `pc_inc`+`en_pc_2` → pc=16'h0012.
  - `pc_inc`+`branch_en`+offset=10'h3FC (-4) → pc=16'h0008.
  - `pc_inc` alone → pc=16'h0010 (refetch).
- Wrap: pc=16'hFFFE with `pc_inc`+`en_pc_2` → pc=16'h0000. `pc_inc` pulsed during FETCH → ignored.
- `rst` asserted during a pending fetch:
  - Next cycle: `imem_req`=0, pc=RESET_PC.
  - A stale ack during reset does not pulse `inst_load`.
- With `IFU_TIMEOUT_EN`, ack never arrives:
  - `fetch_err`=1 after 15 FETCH cycles, `ifu_state`=3, `imem_req`=0.
  - The state persists until `rst`.
